// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the serial instruction loader: default geometry,
// FSM state encoding and a small state-decode helper.
package instruction_loader_pkg;

  localparam int unsigned BYTE_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HDR  = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_CSUM = 3'd3;
  localparam state_t ST_DONE = 3'd4;
  localparam state_t ST_ERR  = 3'd5;

  // States in which the loader consumes stream bytes.
  function automatic logic is_busy(input state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Byte-to-word assembler: collects byte_W bytes little-endian (first byte
// lands in the least significant lane).
//   clk, rst_n   : clock, async active-low reset
//   clear        : synchronous restart of the byte counter and shift register
//   shift_en     : accept in_byte this cycle
//   in_byte      : incoming byte
//   word_c       : word including the current byte (valid with word_done_c)
//   word_done_c  : this shift completes a word
module word_assembler
  import instruction_loader_pkg::*;
#(
  parameter int unsigned byte_W = BYTE_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [7:0]            in_byte,
  output logic [8*byte_W-1:0]   word_c,
  output logic                  word_done_c
);

  localparam int unsigned WORD_W = 8 * byte_W;
  localparam int unsigned CNT_W  = (byte_W > 1) ? $clog2(byte_W) : 1;

  logic [WORD_W-1:0] shreg_q;
  logic [CNT_W-1:0]  cnt_q;

  // New byte enters at the top and older bytes move down one lane, so after
  // byte_W shifts byte 0 sits in bits [7:0].
  always_comb begin
    word_c      = WORD_W'({in_byte, shreg_q} >> 8);
    word_done_c = shift_en && (cnt_q == CNT_W'(byte_W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (clear) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (shift_en) begin
      shreg_q <= word_c;
      cnt_q   <= word_done_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Serial instruction loader: parses header / payload / checksum stream and
// writes assembled words to instruction memory.
//   clk, rst_n          : clock, async active-low reset
//   start               : begin a load (honoured in IDLE, DONE, ERR)
//   in_valid, in_data   : byte stream input
//   in_ready            : byte accepted when in_valid && in_ready
//   mem_we/addr/wdata   : one-cycle word write to instruction memory
//   busy, done, error   : status
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned byte_W = BYTE_W_DEF,
  parameter int unsigned Addr_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [Addr_W-1:0]    mem_addr,
  output logic [8*byte_W-1:0]  mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned WORD_W    = 8 * byte_W;
  localparam int unsigned MAX_WORDS = (2 ** Addr_W) / byte_W;

  state_t            state_q, state_d;
  logic [7:0]        n_words_q;
  logic [7:0]        word_cnt_q;
  logic [Addr_W-1:0] addr_q;
  logic [7:0]        csum_q;

  logic              accept_c;
  logic              load_start_c;
  logic              hdr_ok_c;
  logic              shift_en_c;
  logic              last_word_c;
  logic [WORD_W-1:0] asm_word_c;
  logic              asm_done_c;

  word_assembler #(.byte_W(byte_W)) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (load_start_c),
    .shift_en    (shift_en_c),
    .in_byte     (in_data),
    .word_c      (asm_word_c),
    .word_done_c (asm_done_c)
  );

  // Handshake and datapath qualifiers.
  always_comb begin
    accept_c     = in_valid && in_ready;
    load_start_c = start && !is_busy(state_q);
    hdr_ok_c     = (in_data != 8'd0) && (32'(in_data) <= 32'(MAX_WORDS));
    shift_en_c   = accept_c && (state_q == ST_DATA);
    last_word_c  = asm_done_c && (word_cnt_q == n_words_q - 8'd1);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (load_start_c) state_d = ST_HDR;
      ST_HDR:  if (accept_c) state_d = hdr_ok_c ? ST_DATA : ST_ERR;
      ST_DATA: if (last_word_c) state_d = ST_CSUM;
      ST_CSUM: if (accept_c) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= is_busy(state_d);
      busy     <= is_busy(state_d);
      done     <= (state_d == ST_DONE);
      error    <= (state_d == ST_ERR);
    end
  end

  // Counters, checksum and the memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_words_q  <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      csum_q     <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (load_start_c) begin
        n_words_q  <= '0;
        word_cnt_q <= '0;
        addr_q     <= '0;
        csum_q     <= '0;
      end
      if (accept_c && (state_q == ST_HDR)) begin
        n_words_q <= in_data;
      end
      if (shift_en_c) begin
        csum_q <= csum_q ^ in_data;
      end
      if (asm_done_c) begin
        mem_we     <= 1'b1;
        mem_addr   <= addr_q;
        mem_wdata  <= asm_word_c;
        addr_q     <= addr_q + Addr_W'(byte_W);
        word_cnt_q <= word_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  logic [39:0] exp_q[$];   // {addr, data}
  logic [7:0]  gold[16];
  logic [31:0] gold_w[4];

  instruction_loader #(.byte_W(4), .Addr_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // Write monitor: every mem_we must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we) begin
      vectors++;
      if (exp_q.size() == 0) begin
        assert (1'b0) else begin
          miscompares++;
          $error("FAIL unexpected_write got addr=%h data=%h exp none", mem_addr, mem_wdata);
        end
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        assert ({mem_addr, mem_wdata} === e) else begin
          miscompares++;
          $error("FAIL write got %h exp %h", {mem_addr, mem_wdata}, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte and hold it until the loader accepts it.
  task automatic send_byte(input logic [7:0] b, input bit thr);
    int guard;
    if (thr) begin
      for (int g = 0; g < 4; g++) begin
        if ($urandom_range(0, 1) == 0) break;
        in_valid = 1'b0;
        in_data  = 8'hxx;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_gold();
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(4 * i), gold_w[i]});
  endtask

  task automatic send_payload(input bit thr);
    for (int i = 0; i < 16; i++) send_byte(gold[i], thr);
  endtask

  task automatic drain(input string tag);
    repeat (4) @(negedge clk);
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [127:0] gb;
    gb = 128'h00_10_12_E4_04_30_12_E4_01_21_83_E0_00_00_00_18;
    for (int i = 0; i < 16; i++) gold[i] = gb[127 - 8 * i -: 8];
    gold_w[0] = 32'hE4121000;
    gold_w[1] = 32'hE4123004;
    gold_w[2] = 32'hE0832101;
    gold_w[3] = 32'h18000000;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {50'd0, in_ready, mem_we, mem_addr, busy, done, error}, 64'd0);
    chk("reset_wdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Golden load
    pulse_start();
    chk("hdr_busy", {62'd0, busy, in_ready}, 64'd3);
    push_gold();
    send_byte(8'h04, 1'b0);
    send_payload(1'b0);
    chk("gold_busy_csum", 64'(busy), 64'd1);
    send_byte(8'h7F, 1'b0);
    chk("gold_status", {61'd0, busy, done, error}, 64'b010);
    drain("gold_writes");

    // Bad checksum
    pulse_start();
    push_gold();
    send_byte(8'h04, 1'b0);
    send_payload(1'b0);
    send_byte(8'h7E, 1'b0);
    chk("badcsum_status", {61'd0, busy, done, error}, 64'b001);
    drain("badcsum_writes");

    // Header 0 and header 65 go straight to ERR
    pulse_start();
    send_byte(8'h00, 1'b0);
    chk("hdr0_status", {60'd0, in_ready, busy, done, error}, 64'b0001);
    pulse_start();
    send_byte(8'h41, 1'b0);
    chk("hdr65_status", {60'd0, in_ready, busy, done, error}, 64'b0001);
    drain("hdr_err_writes");

    // Maximum header 64 is accepted
    pulse_start();
    send_byte(8'h40, 1'b0);
    chk("hdr64_busy", {61'd0, busy, done, error}, 64'b100);

    // Throttled golden load (restart from a reset first)
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    push_gold();
    send_byte(8'h04, 1'b1);
    send_payload(1'b1);
    send_byte(8'h7F, 1'b1);
    chk("throttle_status", {61'd0, busy, done, error}, 64'b010);
    drain("throttle_writes");

    // Reset after 6 payload bytes: only the first word is written
    pulse_start();
    exp_q.push_back({8'h00, gold_w[0]});
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 6; i++) send_byte(gold[i], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {50'd0, in_ready, mem_we, mem_addr, busy, done, error}, 64'd0);
    chk("midreset_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drain("midreset_writes");
    pulse_start();
    push_gold();
    send_byte(8'h04, 1'b0);
    send_payload(1'b0);
    send_byte(8'h7F, 1'b0);
    chk("after_reset_status", {61'd0, busy, done, error}, 64'b010);
    drain("after_reset_writes");

    // Start during DATA is ignored
    pulse_start();
    push_gold();
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(gold[i], 1'b0);
    pulse_start();
    chk("start_in_data_busy", {61'd0, busy, done, error}, 64'b100);
    for (int i = 7; i < 16; i++) send_byte(gold[i], 1'b0);
    send_byte(8'h7F, 1'b0);
    chk("start_in_data_status", {61'd0, busy, done, error}, 64'b010);
    drain("start_in_data_writes");

    // DONE holds until start
    repeat (5) @(negedge clk);
    chk("done_hold", {61'd0, busy, done, error}, 64'b010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
